// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states, opcodes,
// ALU select encodings and instruction field positions.
package seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_e;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;

  localparam int unsigned OPCODE_LSB = 24;
  localparam int unsigned DEST_LSB   = 16;
  localparam int unsigned SRC1_LSB   = 8;
  localparam int unsigned SRC2_LSB   = 0;
  localparam int unsigned IMM_LSB    = 0;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder; the sequencer registers its outputs while in DECODE.
module instr_decoder
  import seq_pkg::*;
(
  input  logic [7:0] opcode_i,
  output logic [2:0] alu_select_o,
  output logic       imm_sel_o,
  output logic       neg_sel_o,
  output logic       writes_rf_o,
  output logic       is_halt_o,
  output logic       is_illegal_o
);

  always_comb begin
    alu_select_o = ALU_PASS;
    imm_sel_o    = 1'b0;
    neg_sel_o    = 1'b0;
    writes_rf_o  = 1'b1;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    case (opcode_i)
      OP_LOADI: imm_sel_o = 1'b1;
      OP_MOV:   alu_select_o = ALU_PASS;
      OP_ADD:   alu_select_o = ALU_ADD;
      OP_SUB: begin
        // Subtraction is an add of the negated second operand.
        alu_select_o = ALU_ADD;
        neg_sel_o    = 1'b1;
      end
      OP_AND:   alu_select_o = ALU_AND;
      OP_OR:    alu_select_o = ALU_OR;
      OP_HALT: begin
        writes_rf_o = 1'b0;
        is_halt_o   = 1'b1;
      end
      default: begin
        writes_rf_o  = 1'b0;
        is_illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control FSM for the 8-bit datapath.
// Optional ILLEGAL_TRAP_EN: illegal opcodes halt and set a sticky flag instead of acting as NOPs.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            run_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_valid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [2:0]      rf_out1_addr_o,
  output logic [2:0]      rf_out2_addr_o,
  output logic [2:0]      rf_in_addr_o,
  output logic            rf_we_o,
  output logic [2:0]      alu_select_o,
  output logic            imm_sel_o,
  output logic            neg_sel_o,
  output logic [7:0]      imm_value_o,
  output logic [PC_W-1:0] pc_o,
  output logic            busy_o,
  output logic            halted_o,
  output logic            illegal_o,
  output logic [15:0]     instr_count_o
);

  localparam logic [15:0] CountMax = 16'hFFFF;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     count_q, count_d;

  // Instruction register keeps only the fields that matter.
  logic [7:0] ir_op_q, ir_op_d;
  logic [2:0] ir_dest_q, ir_dest_d;
  logic [2:0] ir_src1_q, ir_src1_d;
  logic [2:0] ir_src2_q, ir_src2_d;
  logic [7:0] ir_imm_q, ir_imm_d;

  logic [2:0] alu_q, alu_d;
  logic       imm_sel_q, imm_sel_d;
  logic       neg_sel_q, neg_sel_d;
  logic       wr_q, wr_d;
  logic [2:0] dest_q, dest_d;
  logic [2:0] src1_q, src1_d;
  logic [2:0] src2_q, src2_d;
  logic [7:0] imm_q, imm_d;

  logic [2:0] dec_alu;
  logic       dec_imm_sel, dec_neg_sel, dec_writes_rf, dec_is_halt, dec_is_illegal;

  logic unused_rdata;
  assign unused_rdata = ^{imem_rdata_i[23:19], imem_rdata_i[15:11]};

  instr_decoder u_decoder (
    .opcode_i     (ir_op_q),
    .alu_select_o (dec_alu),
    .imm_sel_o    (dec_imm_sel),
    .neg_sel_o    (dec_neg_sel),
    .writes_rf_o  (dec_writes_rf),
    .is_halt_o    (dec_is_halt),
    .is_illegal_o (dec_is_illegal)
  );

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    ir_op_d   = ir_op_q;
    ir_dest_d = ir_dest_q;
    ir_src1_d = ir_src1_q;
    ir_src2_d = ir_src2_q;
    ir_imm_d  = ir_imm_q;
    alu_d     = alu_q;
    imm_sel_d = imm_sel_q;
    neg_sel_d = neg_sel_q;
    wr_d      = wr_q;
    dest_d    = dest_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    imm_d     = imm_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        if (imem_valid_i) begin
          ir_op_d   = imem_rdata_i[OPCODE_LSB +: 8];
          ir_dest_d = imem_rdata_i[DEST_LSB +: 3];
          ir_src1_d = imem_rdata_i[SRC1_LSB +: 3];
          ir_src2_d = imem_rdata_i[SRC2_LSB +: 3];
          ir_imm_d  = imem_rdata_i[IMM_LSB +: 8];
          state_d   = StDecode;
        end
      end
      StDecode: begin
        alu_d     = dec_alu;
        imm_sel_d = dec_imm_sel;
        neg_sel_d = dec_neg_sel;
        wr_d      = dec_writes_rf;
        dest_d    = ir_dest_q;
        src1_d    = ir_src1_q;
        src2_d    = ir_src2_q;
        imm_d     = ir_imm_q;
        if (dec_is_halt) begin
          state_d = StHalt;
        end else if (dec_is_illegal) begin
`ifdef ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = StHalt;
`else
          // Retired as a NOP: wr_d is already low from the decoder.
          state_d = StWb;
`endif
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StWb;
      end
      StWb: begin
        pc_d = pc_q + PC_W'(PC_STEP);
        if (count_q != CountMax) count_d = count_q + 16'd1;
        state_d = run_i ? StFetch : StIdle;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      count_q   <= '0;
      ir_op_q   <= '0;
      ir_dest_q <= '0;
      ir_src1_q <= '0;
      ir_src2_q <= '0;
      ir_imm_q  <= '0;
      alu_q     <= ALU_PASS;
      imm_sel_q <= 1'b0;
      neg_sel_q <= 1'b0;
      wr_q      <= 1'b0;
      dest_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      ir_op_q   <= ir_op_d;
      ir_dest_q <= ir_dest_d;
      ir_src1_q <= ir_src1_d;
      ir_src2_q <= ir_src2_d;
      ir_imm_q  <= ir_imm_d;
      alu_q     <= alu_d;
      imm_sel_q <= imm_sel_d;
      neg_sel_q <= neg_sel_d;
      wr_q      <= wr_d;
      dest_q    <= dest_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      imm_q     <= imm_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  assign imem_req_o     = (state_q == StFetch);
  assign imem_addr_o    = pc_q;
  assign pc_o           = pc_q;
  // Gating with reset keeps a write from escaping when reset lands on WB.
  assign rf_we_o        = (state_q == StWb) && wr_q && !reset_i;
  assign rf_out1_addr_o = src1_q;
  assign rf_out2_addr_o = src2_q;
  assign rf_in_addr_o   = dest_q;
  assign alu_select_o   = alu_q;
  assign imm_sel_o      = imm_sel_q;
  assign neg_sel_o      = neg_sel_q;
  assign imm_value_o    = imm_q;
  assign busy_o         = (state_q != StIdle) && (state_q != StHalt);
  assign halted_o       = (state_q == StHalt);
  assign instr_count_o  = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed program plus randomized run/reset/wait stimulus
// against an instruction-level reference model.
module tb_instr_sequencer;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;

  logic        clk;
  logic        reset_i, run_i, imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_req_o, rf_we_o, imm_sel_o, neg_sel_o, busy_o, halted_o, illegal_o;
  logic [31:0] imem_addr_o, pc_o;
  logic [2:0]  rf_out1_addr_o, rf_out2_addr_o, rf_in_addr_o, alu_select_o;
  logic [7:0]  imm_value_o;
  logic [15:0] instr_count_o;

  instr_sequencer #(
    .PC_W     (32),
    .RESET_PC (RST_PC),
    .PC_STEP  (4)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .run_i          (run_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_valid_i   (imem_valid_i),
    .imem_rdata_i   (imem_rdata_i),
    .rf_out1_addr_o (rf_out1_addr_o),
    .rf_out2_addr_o (rf_out2_addr_o),
    .rf_in_addr_o   (rf_in_addr_o),
    .rf_we_o        (rf_we_o),
    .alu_select_o   (alu_select_o),
    .imm_sel_o      (imm_sel_o),
    .neg_sel_o      (neg_sel_o),
    .imm_value_o    (imm_value_o),
    .pc_o           (pc_o),
    .busy_o         (busy_o),
    .halted_o       (halted_o),
    .illegal_o      (illegal_o),
    .instr_count_o  (instr_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Instruction memory: 16 words, indexed by address bits [5:2].
  logic [31:0] mem [16];
  int          dq[$];
  int          wcnt = 0;
  int          cur_delay = 0;

  initial begin
    imem_valid_i = 1'b0;
    imem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req_o) begin
        if (wcnt == 0) cur_delay = (dq.size() > 0) ? dq.pop_front() : $urandom_range(0, 3);
        if (wcnt >= cur_delay) begin
          imem_valid_i = 1'b1;
          imem_rdata_i = mem[imem_addr_o[5:2]];
        end else begin
          imem_valid_i = 1'b0;
          imem_rdata_i = $urandom;
        end
        wcnt++;
      end else begin
        wcnt = 0;
        // Stray valids carrying a HALT opcode must be ignored outside FETCH.
        imem_valid_i = ($urandom_range(0, 3) == 0);
        imem_rdata_i = {8'hFF, 24'($urandom)};
      end
    end
  end

  // Reference model: phase 0 idle, 1 waiting for fetch, 2 decode, 3 execute, 4 writeback, 5 halted.
  int          m_phase = 0;
  logic [31:0] m_ir = '0, m_pc = '0;
  int          m_cnt = 0;
  logic        m_ill = 1'b0, m_wr = 1'b0, m_imm = 1'b0, m_neg = 1'b0;
  logic [2:0]  m_alu = '0, m_d = '0, m_s1 = '0, m_s2 = '0;
  logic [7:0]  m_iv = '0;
  logic [2:0]  alu_tbl [6] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3};

  // kind: 0 writes register file, 1 halt, 2 illegal
  function automatic void op_info(input logic [7:0] op, output logic [2:0] alu, output logic imm,
                                  output logic neg, output int kind);
    alu = 3'd0; imm = 1'b0; neg = 1'b0;
    if (op < 8'd6) begin
      kind = 0;
      alu  = alu_tbl[op];
      imm  = (op == 8'd0);
      neg  = (op == 8'd3);
    end else if (op == 8'hFF) begin
      kind = 1;
    end else begin
      kind = 2;
    end
  endfunction

  task automatic model_step();
    int kind;
    if (reset_i) begin
      m_phase = 0; m_pc = RST_PC; m_cnt = 0; m_ill = 1'b0; m_wr = 1'b0;
      m_alu = '0; m_imm = 1'b0; m_neg = 1'b0; m_d = '0; m_s1 = '0; m_s2 = '0; m_iv = '0;
      return;
    end
    if (m_phase == 0) begin
      if (run_i) m_phase = 1;
    end else if (m_phase == 1) begin
      if (imem_valid_i) begin
        m_ir    = imem_rdata_i;
        m_phase = 2;
      end
    end else if (m_phase == 2) begin
      op_info(m_ir[31:24], m_alu, m_imm, m_neg, kind);
      m_d  = m_ir[18:16];
      m_s1 = m_ir[10:8];
      m_s2 = m_ir[2:0];
      m_iv = m_ir[7:0];
      m_wr = (kind == 0);
      if (kind == 0) m_phase = 3;
      else if (kind == 1) m_phase = 5;
      else begin
`ifdef ILLEGAL_TRAP_EN
        m_ill   = 1'b1;
        m_phase = 5;
`else
        m_phase = 4;
`endif
      end
    end else if (m_phase == 3) begin
      m_phase = 4;
    end else if (m_phase == 4) begin
      m_pc    = m_pc + 32'd4;
      m_cnt   = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
      m_phase = run_i ? 1 : 0;
    end
  endtask

  always @(posedge clk) model_step();

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("imem_req", imem_req_o, m_phase == 1);
      check("imem_addr", imem_addr_o, m_pc);
      check("pc", pc_o, m_pc);
      check("rf_we", rf_we_o, (m_phase == 4) && m_wr && !reset_i);
      check("rf_out1_addr", rf_out1_addr_o, m_s1);
      check("rf_out2_addr", rf_out2_addr_o, m_s2);
      check("rf_in_addr", rf_in_addr_o, m_d);
      check("alu_select", alu_select_o, m_alu);
      check("imm_sel", imm_sel_o, m_imm);
      check("neg_sel", neg_sel_o, m_neg);
      check("imm_value", imm_value_o, m_iv);
      check("busy", busy_o, (m_phase >= 1) && (m_phase <= 4));
      check("halted", halted_o, m_phase == 5);
      check("illegal", illegal_o, m_ill);
      check("instr_count", instr_count_o, m_cnt);
    end
  end

  // Counts negedges until rf_we is seen; also counts cycles with imem_req high.
  task automatic wait_we(output int cycles, output int reqs);
    cycles = 0;
    reqs   = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      cycles++;
      if (imem_req_o) reqs++;
      if (rf_we_o) break;
    end
    check("rf_we_seen", rf_we_o, 1'b1);
  endtask

  task automatic wait_halt(output int we_seen);
    we_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (rf_we_o) we_seen++;
      if (halted_o) break;
    end
    check("halted_seen", halted_o, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    int          r;
    logic [7:0]  op;
    r = $urandom_range(0, 19);
    if (r < 15) op = 8'($urandom_range(0, 5));
    else if (r < 18) op = 8'($urandom_range(6, 254));
    else op = 8'hFF;
    return {op, 24'($urandom)};
  endfunction

  initial begin
    int c, q, we, halt_cnt;
    logic [31:0] pc_hold;
    for (int i = 0; i < 16; i++) mem[i] = 32'hFF00_0000;
    mem[12] = 32'h0002_0005;  // LOADI r2,#5   @ FFFFFFF0
    mem[13] = 32'h0303_0102;  // SUB r3,r1,r2  @ FFFFFFF4
    mem[14] = 32'h0201_0203;  // ADD r1,r2,r3  @ FFFFFFF8
    mem[15] = 32'h0404_0506;  // AND r4,r5,r6  @ FFFFFFFC
    mem[0]  = 32'h0505_0607;  // OR  r5,r6,r7  @ 00000000
    mem[1]  = 32'h7E00_0000;  // illegal       @ 00000004
    mem[2]  = 32'hFF00_0000;  // HALT          @ 00000008
    dq = '{0, 3, 0, 0, 0, 0, 0, 0};
    reset_i = 1'b1;
    run_i   = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    reset_i = 1'b0;
    cmp_en  = 1'b1;

    @(negedge clk); #1;
    check("rst_pc", pc_o, RST_PC);
    check("rst_busy", busy_o, 1'b0);
    check("rst_req", imem_req_o, 1'b0);
    check("rst_count", instr_count_o, 16'd0);

    run_i = 1'b1;
    wait_we(c, q);
    check("loadi_latency", c, 4);
    check("loadi_dest", rf_in_addr_o, 3'd2);
    check("loadi_imm_sel", imm_sel_o, 1'b1);
    check("loadi_alu", alu_select_o, 3'b000);
    check("loadi_imm", imm_value_o, 8'h05);

    wait_we(c, q);
    check("sub_gap", c, 7);
    check("sub_req_cycles", q, 4);
    check("sub_alu", alu_select_o, 3'b001);
    check("sub_neg", neg_sel_o, 1'b1);
    check("sub_src1", rf_out1_addr_o, 3'd1);
    check("sub_src2", rf_out2_addr_o, 3'd2);
    check("sub_dest", rf_in_addr_o, 3'd3);
    check("loadi_pc_after", pc_o, 32'hFFFF_FFF4);
    check("loadi_count_after", instr_count_o, 16'd1);

    wait_we(c, q);
    check("add_gap", c, 4);
    check("add_alu", alu_select_o, 3'b001);
    check("add_neg", neg_sel_o, 1'b0);
    check("add_pc", pc_o, 32'hFFFF_FFF8);
    wait_we(c, q);
    check("and_gap", c, 4);
    check("and_alu", alu_select_o, 3'b010);
    check("and_pc", pc_o, 32'hFFFF_FFFC);
    wait_we(c, q);
    check("or_gap", c, 4);
    check("or_alu", alu_select_o, 3'b011);
    check("or_pc_wrapped", pc_o, 32'h0000_0000);
    check("or_count", instr_count_o, 16'd4);

    wait_halt(we);
    check("illegal_no_we", we, 0);
`ifdef ILLEGAL_TRAP_EN
    check("trap_illegal", illegal_o, 1'b1);
    check("trap_pc", pc_o, 32'h0000_0004);
    check("trap_count", instr_count_o, 16'd5);
`else
    check("nop_illegal_flag", illegal_o, 1'b0);
    check("nop_pc", pc_o, 32'h0000_0008);
    check("nop_count", instr_count_o, 16'd6);
`endif
    pc_hold = pc_o;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("halt_pc_frozen", pc_o, pc_hold);
      check("halt_no_we", rf_we_o, 1'b0);
      check("halt_busy", busy_o, 1'b0);
    end

    // Reset landing in EXEC of a LOADI.
    run_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk); #2;
    reset_i = 1'b0;
    dq.push_back(0);
    @(negedge clk); #1;
    run_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("exec_imm_sel", imm_sel_o, 1'b1);
    reset_i = 1'b1;
    run_i   = 1'b0;
    @(negedge clk); #1;
    check("rst_exec_we", rf_we_o, 1'b0);
    check("rst_exec_busy", busy_o, 1'b0);
    check("rst_exec_pc", pc_o, RST_PC);
    check("rst_exec_imm_sel", imm_sel_o, 1'b0);
    check("rst_exec_dest", rf_in_addr_o, 3'd0);
    check("rst_exec_imm", imm_value_o, 8'd0);
    reset_i = 1'b0;

    // Randomized phase.
    for (int i = 0; i < 16; i++) mem[i] = rand_instr();
    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      halt_cnt = halted_o ? halt_cnt + 1 : 0;
      if (reset_i) reset_i = 1'b0;
      else if (($urandom_range(0, 199) == 0) || (halt_cnt > 5)) reset_i = 1'b1;
      run_i = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) mem[$urandom_range(0, 15)] = rand_instr();
    end

    @(negedge clk); #1;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit datapath: register file 8x8, ALU, immediate MUX, two's-complement MUX.
- Fetches 32-bit instructions from instruction memory over a req/valid handshake and decodes them into register-file addresses, ALU select and MUX controls.
- Issues one register-file write per instruction and advances the PC.
- Replaces the free-running PC counter and the combinational control unit.

Parameters:
- PC_W, 32, program counter width.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, PC increment per retired instruction.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; allows leaving IDLE to fetch.
- imem_req  out  1  fetch request, held until imem_valid.
- imem_addr  out  PC_W  fetch address, always equals pc.
- imem_valid  in  1  instruction data valid this cycle.
- imem_rdata  in  32  instruction word.
- rf_out1_addr  out  3  register-file read port 1 address (src1).
- rf_out2_addr  out  3  register-file read port 2 address (src2).
- rf_in_addr  out  3  register-file write address (dest).
- rf_we  out  1  register-file write strobe, one cycle per instruction.
- alu_select  out  3  ALU operation select.
- imm_sel  out  1  1 selects the immediate as ALU DATA1.
- neg_sel  out  1  1 selects the two's complement of OUT2 as DATA2.
- imm_value  out  8  immediate field.
- pc  out  PC_W  current program counter.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- illegal  out  1  sticky illegal-opcode flag (feature only).
- instr_count  out  16  retired-instruction count.

Behaviour:
- Instruction fields: opcode [31:24], dest [18:16], src1 [10:8], src2 [2:0], imm [7:0]. All other bits are ignored.
- Opcodes and decode (alu_select / imm_sel / neg_sel):
  - 0x00 LOADI: 000 / 1 / 0.
  - 0x01 MOV: 000 / 0 / 0.
  - 0x02 ADD: 001 / 0 / 0.
  - 0x03 SUB: 001 / 0 / 1.
  - 0x04 AND: 010 / 0 / 0.
  - 0x05 OR: 011 / 0 / 0.
  - 0xFF HALT: no register-file write.
  - Any other value is illegal.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: imem_req=0. Goes to FETCH when run=1.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - When imem_valid=1 (including the first FETCH cycle), latch imem_rdata into the instruction register and go to DECODE.
  - Otherwise stay in FETCH with imem_req held.
- DECODE: all decode outputs are registered from the instruction register and stay stable through WB.
  - HALT opcode goes to HALT.
  - Otherwise goes to EXEC.
- EXEC: one cycle for the register-file read and ALU settle. Goes to WB.
- WB:
  - rf_we=1 for exactly this cycle.
  - pc <= pc + PC_STEP, wrapping modulo 2^PC_W.
  - instr_count increments and saturates at 0xFFFF.
  - Goes to FETCH if run=1, else IDLE.
- HALT: terminal. pc and instr_count are frozen, halted=1. Only reset exits.
- Minimum latency is 4 cycles per instruction (FETCH, DECODE, EXEC, WB) when imem_valid arrives in the same cycle as the request.
- imem_valid in any state other than FETCH is ignored.
- run=0 mid-instruction: the instruction completes, then the FSM goes to IDLE after WB.
- Reset value of all outputs is 0, except pc=RESET_PC. State returns to IDLE.
- Reset asserted mid-instruction: no rf_we pulse in the reset cycle. Reset has priority over everything.
- A HALT instruction does not increment instr_count or pc.

Optional Feature:
- ILLEGAL_TRAP_EN defined:
  - An illegal opcode in DECODE sets illegal=1 (sticky until reset) and goes to HALT.
  - No register-file write, pc unchanged.
- ILLEGAL_TRAP_EN undefined:
  - An illegal opcode is a NOP: DECODE goes to WB with rf_we forced to 0.
  - pc and instr_count advance.
  - illegal is tied to 0.

Decomposition:
- Shared package seq_pkg holds:
  - state enum;
  - opcode constants OP_LOADI..OP_OR, OP_HALT;
  - ALU select constants ALU_PASS=000, ALU_ADD=001, ALU_AND=010, ALU_OR=011;
  - field bit-position constants.
- One sub-module: instr_decoder. It is purely combinational: opcode in; alu_select, imm_sel, neg_sel, writes_rf, is_halt, is_illegal out. Its outputs are registered by the FSM in DECODE.

Test Plan:
- Reset then run=1, memory returns LOADI r2,#0x05 (0x00020005) with zero wait → rf_we pulse on cycle 4, rf_in_addr=2, imm_sel=1, alu_select=000, pc=4, instr_count=1.
- SUB r3,r1,r2 (0x03030102) with imem_valid delayed 3 cycles → imem_req held 4 cycles; after that alu_select=001, neg_sel=1, rf_out1_addr=1, rf_out2_addr=2, rf_in_addr=3; single rf_we pulse.
- ADD, AND, OR back-to-back with run held → rf_we pulses exactly 4 cycles apart; alu_select 001, 010, 011; pc 0→4→8→12.
- HALT (0xFF000000) → halted=1, busy=0, no rf_we, pc and instr_count frozen across 20 cycles and continued run.
- Opcode 0x7E → with ILLEGAL_TRAP_EN: illegal=1, halted=1, pc unchanged. Without it: no rf_we, pc += 4, next fetch proceeds.
- reset asserted in EXEC; separately, pc=0xFFFFFFFC before a WB → reset: next cycle all outputs 0, state IDLE, no rf_we. Wrap: pc wraps to 0.
